// File: rtl/inv_key_sched_pkg.sv
// Shared definitions for the inverse AES-128 key schedule.
// Optional feature macro: INV_KEY_SCHED_FWD_EXPAND_EN (adds the EXPAND state).
package inv_key_sched_pkg;

    localparam int          KEY_W       = 128;
    localparam logic [3:0]  LAST_ROUND  = 4'd10;   // round index of the first key emitted
    localparam logic [3:0]  EXPAND_LAST = 4'd9;    // last forward step index (rcon 0..9)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_EXPAND
    } state_t;

    // Round constant by index 0..9; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// One combinational inverse key-schedule step (round r -> r-1).
// With INV_KEY_SCHED_FWD_EXPAND_EN the forward step shares the four S-boxes;
// only the SubWord source differs (w3 forward, w3' inverse).
module inv_key_step
    import inv_key_sched_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [3:0]       rcon_idx,
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    input  logic             fwd,
    output logic [KEY_W-1:0] fwd_key,
`endif
    output logic [KEY_W-1:0] inv_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] i1, i2, i3;
    logic [31:0] sub_in, rot, sub_out, rc_word;

    assign {w0, w1, w2, w3} = key;

    // Undo the XOR chain of the forward schedule, last word first.
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;

`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    assign sub_in = fwd ? w3 : i3;
`else
    assign sub_in = i3;
`endif

    assign rot     = {sub_in[23:0], sub_in[31:24]};
    assign rc_word = {rcon(rcon_idx), 24'h000000};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        softbox u_sbox (
            .a (rot[8*g +: 8]),
            .s (sub_out[8*g +: 8])
        );
    end

    assign inv_key = {w0 ^ sub_out ^ rc_word, i1, i2, i3};

`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    logic [31:0] f0, f1, f2, f3;
    assign f0      = w0 ^ sub_out ^ rc_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/softbox.sv
// AES forward S-box, computed rather than tabled: GF(2^8) inverse as
// a^254 followed by the standard affine transform.
module softbox
    import inv_key_sched_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] inv;
    logic [7:0] sq;

    // Square-and-multiply: a^254 = a^2 * a^4 * ... * a^128 (zero maps to zero).
    always_comb begin
        // NOTE: blocking assignments here because each line feeds the next
        // within one combinational evaluation; registers elsewhere use <=.
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key scheduler: emits round keys 10 down to 0 over a
// valid/ready handshake, one per cycle at full throughput.
// Optional feature macro: INV_KEY_SCHED_FWD_EXPAND_EN -- adds a mode input;
// mode=1 treats key_in as the cipher key and forward-expands it first.
module inv_key_sched
    import inv_key_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    input  logic             mode,
`endif
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q;
    logic [3:0]       round_q;
    logic             done_q;
    logic             accept;
    logic             last;
    logic [3:0]       rcon_idx;
    logic [KEY_W-1:0] inv_key;

    assign accept = (state_q == ST_EMIT) && rk_ready;
    assign last   = (round_q == 4'd0);

`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    logic [KEY_W-1:0] fwd_key;
    logic             expanding;

    assign expanding = (state_q == ST_EXPAND);
    // Forward steps count up through rcon 0..9; inverse uses round-1.
    assign rcon_idx  = expanding ? round_q : round_q - 4'd1;

    inv_key_step u_step (
        .key      (key_q),
        .rcon_idx (rcon_idx),
        .fwd      (expanding),
        .fwd_key  (fwd_key),
        .inv_key  (inv_key)
    );
`else
    assign rcon_idx = round_q - 4'd1;

    inv_key_step u_step (
        .key      (key_q),
        .rcon_idx (rcon_idx),
        .inv_key  (inv_key)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
                    state_d = mode ? ST_EXPAND : ST_EMIT;
`else
                    state_d = ST_EMIT;
`endif
                end
            end
            ST_EMIT: begin
                if (accept && last) state_d = ST_IDLE;
            end
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
            ST_EXPAND: begin
                if (round_q == EXPAND_LAST) state_d = ST_EMIT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: all decoded from registers so they hold steady under backpressure.
    always_comb begin
        rk_out   = key_q;
        rk_round = round_q;
        rk_valid = (state_q == ST_EMIT);
        busy     = (state_q != ST_IDLE);
        done     = done_q;
    end

    // Key register, round counter and the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_q <= key_in;
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
                        round_q <= mode ? 4'd0 : LAST_ROUND;
`else
                        round_q <= LAST_ROUND;
`endif
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (last) begin
                            done_q <= 1'b1;
                        end else begin
                            key_q   <= inv_key;
                            round_q <= round_q - 4'd1;
                        end
                    end
                end
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
                ST_EXPAND: begin
                    key_q   <= fwd_key;
                    round_q <= (round_q == EXPAND_LAST) ? LAST_ROUND : round_q + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched: FIPS-197 keys, backpressure, ignored
// restarts, mid-sequence reset, all-zero key and (with
// INV_KEY_SCHED_FWD_EXPAND_EN) the forward-expand mode.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         busy;
    logic         done;
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
    logic         mode;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_tab [0:10];
    logic [127:0] got     [0:10];

    always #5 clk = ~clk;

    inv_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
        .mode     (mode),
`endif
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Independent reference: brute-force inverse plus bitwise affine matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c   = 8'h63;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [7:0] rc_ref(input int idx);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < idx; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int idx);
        logic [31:0] w0, w1, w2, w3, t, s;
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        for (int b = 0; b < 4; b++) s[8*b +: 8] = sbox_ref(t[8*b +: 8]);
        w0 = w0 ^ s ^ {rc_ref(idx), 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic issue_start(input logic [127:0] k, input bit m);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
        mode   = m;
`else
        if (m) check("mode_unavailable", 1, 0);
`endif
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the negedge where round 10 should be on the output.
    task automatic run_emit(input string name, input bit use_tab, input bit bp,
                            input bit noise, input logic [127:0] noise_key);
        int           r       = 10;
        int           cyc     = 0;
        bit           stalled = 1'b0;
        logic [127:0] held    = '0;
        while (r >= 0 && cyc < 300) begin
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                start  = (r > 0);
                key_in = noise_key;
            end
            check($sformatf("%s_valid_r%0d", name, r), rk_valid, 1);
            check($sformatf("%s_round", name), rk_round, r);
            check($sformatf("%s_done_low", name), done, 0);
            if (use_tab) check($sformatf("%s_key_r%0d", name, r), rk_out, exp_tab[r]);
            if (stalled) check($sformatf("%s_stable_r%0d", name, r), rk_out, held);
            got[r]  = rk_out;
            held    = rk_out;
            stalled = !rk_ready;
            if (rk_ready) r--;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (r >= 0) check($sformatf("%s_timeout", name), 1, 0);
        check($sformatf("%s_done_pulse", name), done, 1);
        check($sformatf("%s_valid_off", name), rk_valid, 0);
        check($sformatf("%s_busy_off", name), busy, 0);
        @(negedge clk);
        check($sformatf("%s_done_once", name), done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        int           wait_cyc;

        exp_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
        mode     = 1'b0;
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", rk_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_key",   rk_out, 0);
        check("rst_round", rk_round, 0);
        rst_n = 1'b1;

        // Full throughput FIPS-197 sequence.
        issue_start(exp_tab[10], 1'b0);
        run_emit("fips", 1'b1, 1'b0, 1'b0, '0);

        // Random backpressure.
        issue_start(exp_tab[10], 1'b0);
        run_emit("bp", 1'b1, 1'b1, 1'b0, '0);

        // Restart requests with a different key while busy are ignored.
        issue_start(exp_tab[10], 1'b0);
        run_emit("restart", 1'b1, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);

        // Asynchronous reset in the middle of a sequence.
        issue_start(exp_tab[10], 1'b0);
        rk_ready = 1'b1;
        wait_cyc = 0;
        while (rk_round != 4'd5 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("mid_reach5", rk_round, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rk_valid, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_done",  done, 0);
        check("mid_rst_key",   rk_out, 0);
        check("mid_rst_round", rk_round, 0);
        @(negedge clk);
        check("mid_rst_no_done", done, 0);
        check("mid_rst_idle",    busy, 0);
        rst_n = 1'b1;
        issue_start(exp_tab[10], 1'b0);
        run_emit("after_rst", 1'b1, 1'b0, 1'b0, '0);

        // All-zero round-10 key: round 9 by hand, the rest via forward re-expansion.
        issue_start('0, 1'b0);
        run_emit("zero", 1'b0, 1'b0, 1'b0, '0);
        check("zero_r10", got[10], 0);
        check("zero_r9",  got[9], 128'h55636363000000000000000000000000);
        k = got[0];
        for (int i = 0; i < 10; i++) begin
            k = fwd_step(k, i);
            check($sformatf("zero_fwd_r%0d", i + 1), got[i + 1], k);
        end
        check("zero_reexpand", k, 0);

`ifdef INV_KEY_SCHED_FWD_EXPAND_EN
        // Cipher key in, ten silent expansion cycles, then the normal sequence.
        issue_start(exp_tab[0], 1'b1);
        mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("exp_busy_%0d", i),  busy, 1);
            check($sformatf("exp_valid_%0d", i), rk_valid, 0);
            @(negedge clk);
        end
        run_emit("expand", 1'b1, 1'b0, 1'b0, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 start  input  1  one-cycle request to begin a key sequence; sampled only in IDLE.
REQ-004 key_in  input  128  round-10 key (word 0 in [127:96]); cipher key when mode=1 (see REQ-021).
REQ-005 rk_ready  input  1  consumer accepts rk_out this cycle.
REQ-006 rk_out  output  128  current round key, word 0 in [127:96].
REQ-007 rk_round  output  4  round index of rk_out, 10 down to 0.
REQ-008 rk_valid  output  1  rk_out/rk_round valid.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse after round-0 key accepted.

Function
REQ-011 States IDLE, EMIT (plus EXPAND under REQ-021); encoding free.
REQ-012 IDLE & start: key_in loaded into key register, round counter set to 10, next state EMIT; rk_valid high the following cycle.
REQ-013 EMIT: rk_valid=1, rk_out=key register, rk_round=round counter; outputs held stable while rk_ready=0.
REQ-014 EMIT & rk_ready & round>0: key register <= inverse step of key register using rcon index round-1; round decrements; rk_valid stays high (one key per cycle at full throughput).
REQ-015 Inverse step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}; RotWord rotates left one byte.
REQ-016 rcon by index 0..9: 01,02,04,08,10,20,40,80,1b,36.
REQ-017 EMIT & rk_ready & round==0: next state IDLE, done=1 for exactly one cycle, rk_valid=0 next cycle.
REQ-018 start while busy ignored; no queueing; key_in changes while busy have no effect.
REQ-019 rk_valid low in IDLE; rk_out/rk_round hold last value in IDLE (not required to clear).

Reset
REQ-020 rst_n low at any time (including mid-sequence): state IDLE, key register 0, round 0, rk_valid 0, busy 0, done 0; sequence abandoned, no done pulse.

Configuration
REQ-021 Macro INV_KEY_SCHED_FWD_EXPAND_EN defined: extra input mode (1 bit); start with mode=1 loads key_in as cipher key, enters EXPAND, runs 10 forward steps (rcon index 0..9, one per cycle, rk_valid=0, busy=1), then EMIT with round=10; start with mode=0 behaves as REQ-012.
REQ-022 Macro undefined: no mode port, no EXPAND state; key_in is always the round-10 key.

Structure
REQ-023 Shared package: key width 128, round count 10, rcon table/function, state type.
REQ-024 Sub-module inv_key_step: combinational inverse step (REQ-015) instantiating four of the team's existing softbox S-boxes; under REQ-021 the forward step is a second combinational path sharing those S-boxes (forward SubWord input w3 vs inverse w3').

Verification
REQ-025 FIPS-197 key: start, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> rk_round 10..0 on 11 consecutive cycles; round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once.
REQ-026 Backpressure: rk_ready toggled randomly -> same 11 keys in order, rk_out stable whenever rk_valid & !rk_ready.
REQ-027 start re-pulsed during EMIT with different key_in -> ignored; sequence completes with original keys.
REQ-028 rst_n asserted at rk_round=5 -> next edge all outputs per REQ-020, no done; fresh start afterwards yields full correct sequence.
REQ-029 Macro defined, mode=1, key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy 10 cycles with rk_valid=0, then round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 followed by REQ-025 sequence.
REQ-030 All-zero key_in as round-10 key -> round 9 equals forward-expand-consistent value (scoreboard forward model re-expands round 0 back to all-zero round 10).
